mmio_uart_buffer: RTL and testbench

Memory-mapped UART buffer between the execute/memory stage and the UART byte engines. Replaces the single-address, unbuffered console access with parameterised RX/TX FIFOs, a status register and a sticky overflow flag. CPU I/O no longer stalls on every byte: it stalls only on read-when-empty or write-when-full. Sits beside `dmem_ram`; the core muxes `io_rdata` into `wb_memdata` when `io_hit_q` is set.

---
 rtl/mmio_uart_buffer.sv | 133 +++++++++++++
 tb/tb_mmio_uart_buffer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_buffer.sv
// mmio_uart_buffer
//   Memory-mapped UART buffer between the execute/memory stage and the UART
//   byte engines. A data register at BASE pops the RX FIFO on load and pushes
//   the TX FIFO on store. A status register at BASE+1 reports the FIFO counts,
//   the sticky RX overflow flag, TX-not-full and RX-non-empty.
//   The pipeline is stalled only for a load when RX is empty, or for a store
//   when TX is full.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   n_stall_in         advance from the other stall sources (1 = advance)
//   req_re, req_we     load / store request this cycle
//   req_addr           request address
//   req_wdata          store data; only [7:0] is used
//   io_n_stall         0 = stall request (combinational, registered flags only)
//   io_hit_q           registered: previous accepted load hit this block
//   io_rdata           registered load data
//   rx_byte, rx_strobe received byte and its one-cycle valid pulse
//   tx_byte, tx_valid  TX FIFO head and non-empty flag
//   tx_ready           transmitter consumes tx_byte when tx_valid && tx_ready
module mmio_uart_buffer #(
  parameter int unsigned       ADDR_W   = 25,
  parameter logic [ADDR_W-1:0] BASE     = '0,
  parameter int unsigned       RX_DEPTH = 16,
  parameter int unsigned       TX_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              n_stall_in,
  input  logic              req_re,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              io_n_stall,
  output logic              io_hit_q,
  output logic [31:0]       io_rdata,
  input  logic [7:0]        rx_byte,
  input  logic              rx_strobe,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_AW + 1;

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [RX_AW-1:0] rx_rptr, rx_wptr;
  logic [TX_AW-1:0] tx_rptr, tx_wptr;
  logic [RX_CW-1:0] rx_count;
  logic [TX_CW-1:0] tx_count;
  logic             rx_ovf;

  logic dsel, ssel, rx_empty, rx_full, tx_full, acc;
  logic rx_pop, rx_push, ovf_set, stat_rd, tx_push, tx_pop;
  logic unused_wdata;

  assign unused_wdata = ^req_wdata[31:8];

  assign dsel     = (req_addr == BASE);
  assign ssel     = (req_addr == BASE + ADDR_W'(1));
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
  assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));

  assign io_n_stall = ~((req_re && dsel && rx_empty) || (req_we && dsel && tx_full));
  assign acc        = n_stall_in && io_n_stall;

  assign rx_pop  = acc && req_re && dsel;
  assign stat_rd = acc && req_re && ssel;
  assign tx_push = acc && req_we && dsel;
  assign tx_pop  = tx_valid && tx_ready;
  // A full RX FIFO still takes the byte when the CPU frees a slot this edge;
  // wptr equals rptr then, and the popped value is read before the overwrite.
  assign rx_push = rx_strobe && (!rx_full || rx_pop);
  assign ovf_set = rx_strobe && !rx_push;

  assign tx_valid = (tx_count != '0);
  assign tx_byte  = tx_mem[tx_rptr];

  // FIFO storage carries no reset.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_byte;
    if (tx_push) tx_mem[tx_wptr] <= req_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_rptr  <= '0;
      rx_wptr  <= '0;
      rx_count <= '0;
      tx_rptr  <= '0;
      tx_wptr  <= '0;
      tx_count <= '0;
      rx_ovf   <= 1'b0;
      io_rdata <= '0;
      io_hit_q <= 1'b0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + RX_AW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + RX_CW'(1);
        2'b01:   rx_count <= rx_count - RX_CW'(1);
        default: rx_count <= rx_count;
      endcase

      if (tx_push) tx_wptr <= tx_wptr + TX_AW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + TX_CW'(1);
        2'b01:   tx_count <= tx_count - TX_CW'(1);
        default: tx_count <= tx_count;
      endcase

      // A new overflow on the same edge as a status read keeps the flag set.
      if (ovf_set)      rx_ovf <= 1'b1;
      else if (stat_rd) rx_ovf <= 1'b0;

      if (n_stall_in) begin
        io_hit_q <= acc && req_re && (dsel || ssel);
        if (rx_pop)
          io_rdata <= {24'b0, rx_mem[rx_rptr]};
        else if (stat_rd)
          io_rdata <= {8'b0, 8'(tx_count), 8'(rx_count), 5'b0,
                       rx_ovf, !tx_full, !rx_empty};
      end
    end
  end

endmodule

// File: tb/tb_mmio_uart_buffer.sv
module tb_mmio_uart_buffer;

  localparam logic [24:0] BASE = 25'h40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        n_stall_in = 1'b1;
  logic        req_re = 1'b0;
  logic        req_we = 1'b0;
  logic [24:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        io_n_stall;
  logic        io_hit_q;
  logic [31:0] io_rdata;
  logic [7:0]  rx_byte = '0;
  logic        rx_strobe = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmio_uart_buffer #(
    .ADDR_W  (25),
    .BASE    (BASE),
    .RX_DEPTH(16),
    .TX_DEPTH(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .n_stall_in(n_stall_in),
    .req_re    (req_re),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .io_n_stall(io_n_stall),
    .io_hit_q  (io_hit_q),
    .io_rdata  (io_rdata),
    .rx_byte   (rx_byte),
    .rx_strobe (rx_strobe),
    .tx_byte   (tx_byte),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  // Stimulus helpers: inputs change only at the falling edge.
  task automatic do_load(input logic [24:0] a, output logic [31:0] d, output logic h);
    req_re = 1'b1; req_addr = a;
    @(negedge clk);
    req_re = 1'b0;
    d = io_rdata; h = io_hit_q;
  endtask

  task automatic do_store(input logic [24:0] a, input logic [7:0] b);
    req_we = 1'b1; req_addr = a; req_wdata = {24'hABCDEF, b};
    @(negedge clk);
    req_we = 1'b0;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_strobe = 1'b1; rx_byte = b;
    @(negedge clk);
    rx_strobe = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (io_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", io_rdata, 32'h0); end
    checks++;
    if (io_hit_q !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", io_hit_q); end
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_stall;
    req_re = 1'b1; req_addr = BASE;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (io_n_stall !== 1'b0) begin failures++; $display("FAIL stall_empty[%0d] got=%b exp=0", i, io_n_stall); end
      @(negedge clk);
    end
    rx_strobe = 1'b1; rx_byte = 8'h41;
    @(negedge clk);
    rx_strobe = 1'b0;
    #1;
    checks++;
    if (io_n_stall !== 1'b1) begin failures++; $display("FAIL stall_release got=%b exp=1", io_n_stall); end
    checks++;
    if (io_hit_q !== 1'b0) begin failures++; $display("FAIL stall_hit_early got=%b exp=0", io_hit_q); end
    @(negedge clk);
    req_re = 1'b0;
    checks++;
    if (io_rdata !== 32'h41 || io_hit_q !== 1'b1)
      begin failures++; $display("FAIL stall_read got=%h/%b exp=%h/1", io_rdata, io_hit_q, 32'h41); end
    @(negedge clk);
    checks++;
    if (io_hit_q !== 1'b0) begin failures++; $display("FAIL hit_drop got=%b exp=0", io_hit_q); end
  endtask

  task automatic test_rx_overflow;
    logic [31:0] d;
    logic        h;
    for (int i = 0; i < 16; i++) push_rx(8'(i));
    push_rx(8'hFF);
    do_load(BASE + 25'd1, d, h);
    checks++;
    if (d !== 32'h0000_1007 || h !== 1'b1) begin failures++; $display("FAIL ovf_status got=%h/%b exp=%h/1", d, h, 32'h0000_1007); end
    do_load(BASE + 25'd1, d, h);
    checks++;
    if (d !== 32'h0000_1003) begin failures++; $display("FAIL ovf_cleared got=%h exp=%h", d, 32'h0000_1003); end
    for (int i = 0; i < 16; i++) begin
      do_load(BASE, d, h);
      checks++;
      if (d !== 32'(i) || h !== 1'b1) begin failures++; $display("FAIL rx_order[%0d] got=%h exp=%h", i, d, 32'(i)); end
    end
    do_load(BASE + 25'd1, d, h);
    checks++;
    if (d !== 32'h0000_0002) begin failures++; $display("FAIL rx_drained got=%h exp=%h", d, 32'h0000_0002); end
  endtask

  task automatic test_rx_full_coincide;
    logic [31:0] d;
    logic        h;
    for (int i = 0; i < 16; i++) push_rx(8'(8'h10 + i));
    rx_strobe = 1'b1; rx_byte = 8'hAA;
    do_load(BASE, d, h);
    rx_strobe = 1'b0;
    checks++;
    if (d !== 32'h10) begin failures++; $display("FAIL coincide_read got=%h exp=%h", d, 32'h10); end
    do_load(BASE + 25'd1, d, h);
    checks++;
    if (d !== 32'h0000_1003) begin failures++; $display("FAIL coincide_status got=%h exp=%h", d, 32'h0000_1003); end
    for (int i = 1; i < 17; i++) begin
      do_load(BASE, d, h);
      checks++;
      if (d !== ((i == 16) ? 32'hAA : 32'(8'h10 + i)))
        begin failures++; $display("FAIL coincide_order[%0d] got=%h exp=%h", i, d, (i == 16) ? 32'hAA : 32'(8'h10 + i)); end
    end
  endtask

  task automatic test_tx_full;
    logic [31:0] d;
    logic        h;
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) do_store(BASE, 8'(8'h50 + i));
    req_we = 1'b1; req_addr = BASE; req_wdata = 32'h0000_00EE;
    #1;
    checks++;
    if (io_n_stall !== 1'b0) begin failures++; $display("FAIL tx_full_stall got=%b exp=0", io_n_stall); end
    checks++;
    if (tx_byte !== 8'h50 || tx_valid !== 1'b1) begin failures++; $display("FAIL tx_head got=%h/%b exp=50/1", tx_byte, tx_valid); end
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    #1;
    checks++;
    if (io_n_stall !== 1'b1) begin failures++; $display("FAIL tx_unstall got=%b exp=1", io_n_stall); end
    @(negedge clk);
    req_we = 1'b0;
    do_load(BASE + 25'd1, d, h);
    checks++;
    if (d !== 32'h0010_0000) begin failures++; $display("FAIL tx_full_status got=%h exp=%h", d, 32'h0010_0000); end
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_byte !== ((i == 15) ? 8'hEE : 8'(8'h51 + i)))
        begin failures++; $display("FAIL tx_drain[%0d] got=%h/%b exp=%h", i, tx_byte, tx_valid, (i == 15) ? 8'hEE : 8'(8'h51 + i)); end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_empty got=%b exp=0", tx_valid); end
  endtask

  task automatic test_back_to_back;
    int seen = 0;
    int stalls = 0;
    tx_ready = 1'b1;
    for (int c = 0; c < 44; c++) begin
      if (c < 40) begin
        req_we = 1'b1; req_addr = BASE; req_wdata = 32'(8'(c * 3 + 7));
      end else begin
        req_we = 1'b0;
      end
      #1;
      if (req_we && io_n_stall !== 1'b1) stalls++;
      if (tx_valid === 1'b1) begin
        checks++;
        if (tx_byte !== 8'(seen * 3 + 7))
          begin failures++; $display("FAIL stream[%0d] got=%h exp=%h", seen, tx_byte, 8'(seen * 3 + 7)); end
        seen++;
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    checks++;
    if (seen !== 40 || stalls !== 0) begin failures++; $display("FAIL stream_count got=%0d stalls=%0d exp=40 stalls=0", seen, stalls); end
  endtask

  task automatic test_bad_addr;
    logic [31:0] d;
    logic        h;
    req_we = 1'b1; req_addr = BASE + 25'd2; req_wdata = 32'h77;
    #1;
    checks++;
    if (io_n_stall !== 1'b1) begin failures++; $display("FAIL bad_store_stall got=%b exp=1", io_n_stall); end
    @(negedge clk);
    req_addr = BASE + 25'd1;
    @(negedge clk);
    req_we = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL bad_store_push got=%b exp=0", tx_valid); end
    req_re = 1'b1; req_addr = BASE + 25'd2;
    #1;
    checks++;
    if (io_n_stall !== 1'b1) begin failures++; $display("FAIL bad_load_stall got=%b exp=1", io_n_stall); end
    @(negedge clk);
    req_re = 1'b0;
    checks++;
    if (io_hit_q !== 1'b0) begin failures++; $display("FAIL bad_load_hit got=%b exp=0", io_hit_q); end
    do_load(BASE + 25'd1, d, h);
    checks++;
    if (d !== 32'h0000_0002) begin failures++; $display("FAIL bad_status got=%h exp=%h", d, 32'h0000_0002); end
  endtask

  task automatic test_hold;
    logic [31:0] d;
    logic        h;
    push_rx(8'h5A);
    do_load(BASE + 25'd1, d, h);
    n_stall_in = 1'b0;
    req_re = 1'b1; req_addr = BASE;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (io_hit_q !== 1'b1 || io_rdata !== 32'h0000_0103)
      begin failures++; $display("FAIL hold got=%h/%b exp=%h/1", io_rdata, io_hit_q, 32'h0000_0103); end
    n_stall_in = 1'b1;
    req_re = 1'b0;
    do_load(BASE, d, h);
    checks++;
    if (d !== 32'h5A) begin failures++; $display("FAIL hold_no_pop got=%h exp=%h", d, 32'h5A); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic        h;
    push_rx(8'h11);
    push_rx(8'h22);
    do_store(BASE, 8'h33);
    req_re = 1'b1; req_addr = BASE;
    @(negedge clk);
    req_re = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (io_rdata !== 32'h0 || io_hit_q !== 1'b0 || tx_valid !== 1'b0)
      begin failures++; $display("FAIL async_reset got=%h/%b/%b exp=0/0/0", io_rdata, io_hit_q, tx_valid); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_load(BASE + 25'd1, d, h);
    checks++;
    if (d !== 32'h0000_0002) begin failures++; $display("FAIL reset_counts got=%h exp=%h", d, 32'h0000_0002); end
  endtask

  initial begin
    test_reset;
    test_read_stall;
    test_rx_overflow;
    test_rx_full_coincide;
    test_tx_full;
    test_back_to_back;
    test_bad_addr;
    test_hold;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
